// File: rtl/mul_div_unit_if.sv
// Request/result bundle for mul_div_unit: operands and mode in, results and status out.
// Vectors are MSB-first ([0:WIDTH-1], bit 0 is the MSB).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Signed;
    logic             Op;
    logic [0:WIDTH-1] A;
    logic [0:WIDTH-1] B;
    logic [0:WIDTH-1] Lo;
    logic [0:WIDTH-1] Hi;
    logic             Ready;
    logic             Busy;
    logic             DivZero;

    modport master (
        output Start, Signed, Op, A, B,
        input  Lo, Hi, Ready, Busy, DivZero
    );

    modport slave (
        input  Start, Signed, Op, A, B,
        output Lo, Hi, Ready, Busy, DivZero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiplier/divider: one bit per cycle on operand magnitudes, sign fix at the end.
// Define MUL_DIV_UNIT_DIVIDE_EN to build the divide path; otherwise every operation is a multiply.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Mul: {partial product, multiplier}; div: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     a_in, b_in, a_mag, b_mag;
    logic                 a_sign, b_sign;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   mul_res;

`ifdef MUL_DIV_UNIT_DIVIDE_EN
    logic                 op_div_q, op_div_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, rem;
    logic                 b_zero;
`else
    logic                 unused_op;
    assign unused_op = bus.Op;
`endif

    // Ascending-range ports copy into descending vectors MSB to MSB, so values are preserved.
    assign a_in   = bus.A;
    assign b_in   = bus.B;
    assign a_sign = bus.Signed & a_in[WIDTH-1];
    assign b_sign = bus.Signed & b_in[WIDTH-1];
    assign a_mag  = a_sign ? -a_in : a_in;
    assign b_mag  = b_sign ? -b_in : b_in;

    // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_res  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;

`ifdef MUL_DIV_UNIT_DIVIDE_EN
    // Restoring step: keep the subtraction only when it does not borrow.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quo    = acc_q[WIDTH-1:0];
    assign rem    = acc_q[2*WIDTH-1:WIDTH];
    assign b_zero = (opb_q == '0);
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ready_d = ready_q;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
        op_div_d   = op_div_q;
        div_zero_d = div_zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    a_neg_d = a_sign;
                    b_neg_d = b_sign;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = CALC;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                    op_div_d = bus.Op;
`endif
                end
            end
            CALC: begin
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                acc_d = op_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = mul_res;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                div_zero_d = 1'b0;
                if (op_div_q) begin
                    // Remainder follows the dividend sign, which also returns A untouched on B == 0.
                    hi_d       = a_neg_q ? -rem : rem;
                    lo_d       = b_zero ? {WIDTH{1'b1}} : ((a_neg_q ^ b_neg_q) ? -quo : quo);
                    div_zero_d = b_zero;
                end
`endif
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath registers are reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            ready_q <= 1'b0;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
            op_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ready_q <= ready_d;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
            op_div_q   <= op_div_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign bus.Lo    = lo_q;
    assign bus.Hi    = hi_q;
    assign bus.Ready = ready_q;
    assign bus.Busy  = (state_q != IDLE);
`ifdef MUL_DIV_UNIT_DIVIDE_EN
    assign bus.DivZero = div_zero_q;
`else
    assign bus.DivZero = 1'b0;
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32): latency, signed/unsigned results, busy/ready
// behaviour, mid-operation reset, and divide or multiply-only behaviour depending on the build.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.Signed = sgn; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (bus.Ready !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        accept(op, sgn, a, b);
        wait_ready(lat);
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.Op = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.Ready !== 1'b0)   begin n_bad++; $display("FAIL reset_ready: got %b expected 0", bus.Ready); end
        n_cmp++; if (bus.Busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.DivZero !== 1'b0) begin n_bad++; $display("FAIL reset_divzero: got %b expected 0", bus.DivZero); end
        n_cmp++; if (bus.Lo !== 32'h0)     begin n_bad++; $display("FAIL reset_lo: got %h expected 0", bus.Lo); end
        n_cmp++; if (bus.Hi !== 32'h0)     begin n_bad++; $display("FAIL reset_hi: got %h expected 0", bus.Hi); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul_unsigned();
        int lat;
        do_op(1'b0, 1'b0, 32'd3, 32'd5, lat);
        n_cmp++; if (lat !== 33)          begin n_bad++; $display("FAIL mul3x5_lat: got %0d expected 33", lat); end
        n_cmp++; if (bus.Lo !== 32'd15)   begin n_bad++; $display("FAIL mul3x5_lo: got %h expected %h", bus.Lo, 32'd15); end
        n_cmp++; if (bus.Hi !== 32'd0)    begin n_bad++; $display("FAIL mul3x5_hi: got %h expected 0", bus.Hi); end
        n_cmp++; if (bus.Busy !== 1'b0)   begin n_bad++; $display("FAIL mul3x5_busy: got %b expected 0", bus.Busy); end
        // Second op: results must hold the old value until the FIX edge.
        accept(1'b0, 1'b0, 32'd7, 32'd9);
        n_cmp++; if (bus.Ready !== 1'b0)  begin n_bad++; $display("FAIL mul7x9_ready_cleared: got %b expected 0", bus.Ready); end
        n_cmp++; if (bus.Busy !== 1'b1)   begin n_bad++; $display("FAIL mul7x9_busy_set: got %b expected 1", bus.Busy); end
        lat = 0;
        while (lat < 32) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (bus.Lo !== 32'd15)   begin n_bad++; $display("FAIL mul7x9_hold_lo: got %h expected %h", bus.Lo, 32'd15); end
        n_cmp++; if (bus.Ready !== 1'b0)  begin n_bad++; $display("FAIL mul7x9_edge32_ready: got %b expected 0", bus.Ready); end
        @(posedge clk); #1; lat++;
        n_cmp++; if (bus.Ready !== 1'b1)  begin n_bad++; $display("FAIL mul7x9_edge33_ready: got %b expected 1", bus.Ready); end
        n_cmp++; if (bus.Lo !== 32'd63)   begin n_bad++; $display("FAIL mul7x9_lo: got %h expected %h", bus.Lo, 32'd63); end
    endtask

    task automatic test_mul_signed();
        int lat;
        do_op(1'b0, 1'b1, 32'hFFFFFFFC, 32'd8, lat);
        n_cmp++; if (bus.Hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL smul_m4x8_hi: got %h expected FFFFFFFF", bus.Hi); end
        n_cmp++; if (bus.Lo !== 32'hFFFFFFE0) begin n_bad++; $display("FAIL smul_m4x8_lo: got %h expected FFFFFFE0", bus.Lo); end
        do_op(1'b0, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFF4, lat);
        n_cmp++; if (bus.Lo !== 32'd180)      begin n_bad++; $display("FAIL smul_m15xm12_lo: got %h expected %h", bus.Lo, 32'd180); end
        n_cmp++; if (bus.Hi !== 32'd0)        begin n_bad++; $display("FAIL smul_m15xm12_hi: got %h expected 0", bus.Hi); end
        do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_cmp++; if (bus.Hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL umul_max_hi: got %h expected FFFFFFFE", bus.Hi); end
        n_cmp++; if (bus.Lo !== 32'h00000001) begin n_bad++; $display("FAIL umul_max_lo: got %h expected 00000001", bus.Lo); end
        n_cmp++; if (lat !== 33)              begin n_bad++; $display("FAIL umul_max_lat: got %0d expected 33", lat); end
    endtask

`ifdef MUL_DIV_UNIT_DIVIDE_EN
    task automatic test_divide();
        int lat;
        do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
        n_cmp++; if (bus.Lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL sdiv_m7_2_lo: got %h expected FFFFFFFD", bus.Lo); end
        n_cmp++; if (bus.Hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL sdiv_m7_2_hi: got %h expected FFFFFFFF", bus.Hi); end
        n_cmp++; if (bus.DivZero !== 1'b0)    begin n_bad++; $display("FAIL sdiv_m7_2_dz: got %b expected 0", bus.DivZero); end
        do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
        n_cmp++; if (bus.Lo !== 32'h80000000) begin n_bad++; $display("FAIL sdiv_minneg_lo: got %h expected 80000000", bus.Lo); end
        n_cmp++; if (bus.Hi !== 32'h0)        begin n_bad++; $display("FAIL sdiv_minneg_hi: got %h expected 0", bus.Hi); end
        do_op(1'b1, 1'b0, 32'd100, 32'd7, lat);
        n_cmp++; if (bus.Lo !== 32'd14)       begin n_bad++; $display("FAIL udiv_100_7_lo: got %h expected %h", bus.Lo, 32'd14); end
        n_cmp++; if (bus.Hi !== 32'd2)        begin n_bad++; $display("FAIL udiv_100_7_hi: got %h expected %h", bus.Hi, 32'd2); end
        do_op(1'b1, 1'b0, 32'd100, 32'd0, lat);
        n_cmp++; if (bus.DivZero !== 1'b1)    begin n_bad++; $display("FAIL div0_dz: got %b expected 1", bus.DivZero); end
        n_cmp++; if (bus.Lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo: got %h expected FFFFFFFF", bus.Lo); end
        n_cmp++; if (bus.Hi !== 32'd100)      begin n_bad++; $display("FAIL div0_hi: got %h expected %h", bus.Hi, 32'd100); end
        n_cmp++; if (lat !== 33)              begin n_bad++; $display("FAIL div0_lat: got %0d expected 33", lat); end
        do_op(1'b0, 1'b0, 32'd2, 32'd3, lat);
        n_cmp++; if (bus.DivZero !== 1'b0)    begin n_bad++; $display("FAIL mul_after_div0_dz: got %b expected 0", bus.DivZero); end
        n_cmp++; if (bus.Lo !== 32'd6)        begin n_bad++; $display("FAIL mul_after_div0_lo: got %h expected %h", bus.Lo, 32'd6); end
        do_op(1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, lat);
        n_cmp++; if (bus.Lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL sdiv0_lo: got %h expected FFFFFFFF", bus.Lo); end
        n_cmp++; if (bus.Hi !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL sdiv0_hi: got %h expected FFFFFFFB", bus.Hi); end
    endtask
`else
    task automatic test_divide();
        int lat;
        do_op(1'b1, 1'b0, 32'd6, 32'd7, lat);
        n_cmp++; if (bus.Lo !== 32'd42)       begin n_bad++; $display("FAIL nodiv_op1_lo: got %h expected %h", bus.Lo, 32'd42); end
        n_cmp++; if (bus.Hi !== 32'd0)        begin n_bad++; $display("FAIL nodiv_op1_hi: got %h expected 0", bus.Hi); end
        n_cmp++; if (bus.DivZero !== 1'b0)    begin n_bad++; $display("FAIL nodiv_op1_dz: got %b expected 0", bus.DivZero); end
        n_cmp++; if (lat !== 33)              begin n_bad++; $display("FAIL nodiv_op1_lat: got %0d expected 33", lat); end
        do_op(1'b1, 1'b0, 32'd100, 32'd0, lat);
        n_cmp++; if (bus.Lo !== 32'd0)        begin n_bad++; $display("FAIL nodiv_b0_lo: got %h expected 0", bus.Lo); end
        n_cmp++; if (bus.DivZero !== 1'b0)    begin n_bad++; $display("FAIL nodiv_b0_dz: got %b expected 0", bus.DivZero); end
    endtask
`endif

    task automatic test_start_ignored();
        int lat, lat2;
        accept(1'b0, 1'b0, 32'd11, 32'd13);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b1; bus.A = 32'd2; bus.B = 32'd2; bus.Signed = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_ready(lat2);
        lat = 6 + lat2;
        n_cmp++; if (lat !== 33)           begin n_bad++; $display("FAIL ignore_start_lat: got %0d expected 33", lat); end
        n_cmp++; if (bus.Lo !== 32'd143)   begin n_bad++; $display("FAIL ignore_start_lo: got %h expected %h", bus.Lo, 32'd143); end
        n_cmp++; if (bus.Hi !== 32'd0)     begin n_bad++; $display("FAIL ignore_start_hi: got %h expected 0", bus.Hi); end
    endtask

    task automatic test_reset_mid();
        int lat;
        accept(1'b0, 1'b0, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.Ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b expected 0", bus.Ready); end
        n_cmp++; if (bus.Busy !== 1'b0)  begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Lo !== 32'd0)   begin n_bad++; $display("FAIL midrst_lo: got %h expected 0", bus.Lo); end
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 1'b0, 32'd6, 32'd7, lat);
        n_cmp++; if (lat !== 33)         begin n_bad++; $display("FAIL after_rst_lat: got %0d expected 33", lat); end
        n_cmp++; if (bus.Lo !== 32'd42)  begin n_bad++; $display("FAIL after_rst_lo: got %h expected %h", bus.Lo, 32'd42); end
    endtask

    task automatic test_back_to_back();
        int lat;
        // Start held high: the edge where Ready rises must not accept, the following one must.
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 1'b0; bus.Signed = 1'b0; bus.A = 32'd4; bus.B = 32'd5;
        @(posedge clk); #1;
        wait_ready(lat);
        n_cmp++; if (lat !== 33)          begin n_bad++; $display("FAIL b2b_lat: got %0d expected 33", lat); end
        n_cmp++; if (bus.Lo !== 32'd20)   begin n_bad++; $display("FAIL b2b_lo: got %h expected %h", bus.Lo, 32'd20); end
        n_cmp++; if (bus.Busy !== 1'b0)   begin n_bad++; $display("FAIL b2b_busy_at_ready: got %b expected 0", bus.Busy); end
        @(posedge clk); #1;
        n_cmp++; if (bus.Ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_next_ready: got %b expected 0", bus.Ready); end
        n_cmp++; if (bus.Busy !== 1'b1)   begin n_bad++; $display("FAIL b2b_next_busy: got %b expected 1", bus.Busy); end
        bus.Start = 1'b0;
        wait_ready(lat);
        n_cmp++; if (bus.Lo !== 32'd20)   begin n_bad++; $display("FAIL b2b_second_lo: got %h expected %h", bus.Lo, 32'd20); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.Ready !== 1'b1)  begin n_bad++; $display("FAIL ready_level_hold: got %b expected 1", bus.Ready); end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_divide();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
